// File: rtl/izhikevich_neuron_array.sv
// rtl/izhikevich_neuron_array.sv - time-multiplexed Izhikevich neuron core, one shared Euler datapath.
// Define IZH_SATURATE_EN to clamp all products and sums instead of wrapping.
module izhikevich_neuron_array #(
  parameter int N       = 18,
  parameter int Q       = 10,
  parameter int NEURONS = 8,
  parameter logic signed [N-1:0] K2     = 18'sd4096,
  parameter logic signed [N-1:0] K1     = 18'sd5120,
  parameter logic signed [N-1:0] K0     = 18'sd1433,
  parameter logic signed [N-1:0] A      = 18'sd20,
  parameter logic signed [N-1:0] B      = 18'sd205,
  parameter logic signed [N-1:0] C      = -18'sd666,
  parameter logic signed [N-1:0] D      = 18'sd82,
  parameter logic signed [N-1:0] V_PEAK = 18'sd307,
  localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         step,
  input  logic [NEURONS*N-1:0] i_flat,
  output logic                 busy,
  output logic                 done,
  output logic [NEURONS-1:0]   spikes,
  input  logic [IW-1:0]        rd_idx,
  output logic [N-1:0]         rd_v,
  output logic [N-1:0]         rd_w
);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, UPDATE, DONE} state_t;

  localparam logic signed [2*N-1:0] MAXV   = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MINV   = {{(N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [IW-1:0]         K_LAST = IW'(NEURONS - 1);

  function automatic logic signed [N-1:0] fit(input logic signed [2*N-1:0] x);
`ifdef IZH_SATURATE_EN
    if (x > MAXV)      fit = MAXV[N-1:0];
    else if (x < MINV) fit = MINV[N-1:0];
    else               fit = x[N-1:0];
`else
    fit = x[N-1:0];
`endif
  endfunction

  function automatic logic signed [N-1:0] mulq(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = a * b;
    mulq = fit(p >>> Q);
  endfunction

  function automatic logic signed [N-1:0] addq(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ea, eb;
    ea = a;
    eb = b;
    addq = fit(ea + eb);
  endfunction

  function automatic logic signed [N-1:0] subq(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
    logic signed [2*N-1:0] ea, eb;
    ea = a;
    eb = b;
    subq = fit(ea - eb);
  endfunction

  state_t                state;
  logic [IW-1:0]         k;
  logic signed [N-1:0]   v_mem [NEURONS];
  logic signed [N-1:0]   w_mem [NEURONS];
  logic [NEURONS*N-1:0]  i_s;
  logic signed [N-1:0]   step_r, v_r, w_r, i_r, dv_r, dw_r;
  logic signed [N-1:0]   dv_c, dw_c, v_n, w_n, t;

  // Shared datapath: operator order follows the dv/dw formulas left to right.
  always_comb begin
    t    = mulq(mulq(K2, v_r), v_r);
    t    = addq(t, mulq(K1, v_r));
    t    = addq(t, K0);
    t    = subq(t, w_r);
    t    = addq(t, i_r);
    dv_c = mulq(t, step_r);
    dw_c = mulq(mulq(A, subq(mulq(B, v_r), w_r)), step_r);
    v_n  = addq(v_r, dv_r);
    w_n  = addq(w_r, dw_r);
  end

  always_comb begin
    rd_v = '0;
    rd_w = '0;
    if (32'(rd_idx) < NEURONS) begin
      rd_v = v_mem[rd_idx];
      rd_w = w_mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      spikes <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        v_mem[n] <= C;
        w_mem[n] <= mulq(B, C);
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          step_r <= step;
          i_s    <= i_flat;
          k      <= '0;
          busy   <= 1'b1;
          spikes <= '0;
          state  <= FETCH;
        end
        FETCH: begin
          v_r   <= v_mem[k];
          w_r   <= w_mem[k];
          i_r   <= i_s[k*N +: N];
          state <= CALC;
        end
        CALC: begin
          dv_r  <= dv_c;
          dw_r  <= dw_c;
          state <= UPDATE;
        end
        UPDATE: begin
          if (v_n >= V_PEAK) begin
            v_mem[k]  <= C;
            w_mem[k]  <= addq(w_n, D);
            spikes[k] <= 1'b1;
          end else begin
            v_mem[k]  <= v_n;
            w_mem[k]  <= w_n;
            spikes[k] <= 1'b0;
          end
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            k     <= k + 1'b1;
            state <= FETCH;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
